udma_apb_cfg_bridge: RTL and testbench

APB3 slave that converts processor register accesses into transactions on the uDMA configuration bus. It is the initiator end of that bus and drives one cfg port per peripheral: the uDMA control register file and each peripheral's channel/config registers. It decodes the APB address into a peripheral index and a 5-bit register index, then holds the request until the selected responder asserts ready. A timeout counter covers responders that never answer.

---
 rtl/udma_apb_cfg_bridge.sv | 141 ++++++++++++++
 tb/tb_udma_apb_cfg_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_apb_cfg_bridge.sv
// APB3 slave bridging processor register accesses onto the uDMA configuration bus.
// One request is in flight at a time; a per-request timeout aborts stalled accesses.
module udma_apb_cfg_bridge #(
   parameter int unsigned N_PERIPHS      = 8,
   parameter int unsigned APB_ADDR_WIDTH = 12,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      psel_i,
   input  logic                      penable_i,
   input  logic                      pwrite_i,
   input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
   input  logic [31:0]               pwdata_i,
   output logic [31:0]               prdata_o,
   output logic                      pready_o,
   output logic                      pslverr_o,
   output logic [N_PERIPHS-1:0]      cfg_valid_o,
   output logic [4:0]                cfg_addr_o,
   output logic [31:0]               cfg_data_o,
   output logic                      cfg_rwn_o,
   input  logic [N_PERIPHS*32-1:0]   cfg_data_i,
   input  logic [N_PERIPHS-1:0]      cfg_ready_i
);

   typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

   state_e      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [4:0]  addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        rwn_q, rwn_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        sel_ready;
   logic [31:0] sel_data;
   logic [4:0]  paddr_idx;

   // Byte-offset bits and anything above the 4 KiB window carry no meaning here.
   logic [APB_ADDR_WIDTH-1:0] unused_paddr;
   assign unused_paddr = paddr_i;
   assign paddr_idx    = paddr_i[11:7];

   always_comb begin
      sel_ready = 1'b0;
      sel_data  = '0;
      for (int unsigned i = 0; i < N_PERIPHS; i++) begin
         if (idx_q == 5'(i)) begin
            sel_ready = cfg_ready_i[i];
            sel_data  = cfg_data_i[i*32 +: 32];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rwn_d   = rwn_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (psel_i && !penable_i) begin
               addr_d = paddr_i[6:2];
               data_d = pwdata_i;
               rwn_d  = ~pwrite_i;
               idx_d  = paddr_idx;
               if (32'(paddr_idx) < N_PERIPHS) begin
                  state_d = StReq;
                  cnt_d   = '0;
               end else begin
                  state_d = StDone;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end
            end
         end
         StReq: begin
            if (sel_ready) begin
               rdata_d = rwn_q ? sel_data : 32'h0;
               err_d   = 1'b0;
               state_d = StDone;
            end else if (cnt_q == 8'(TIMEOUT_CYCLES)) begin
               // Responder never answered: valid has been up for TIMEOUT_CYCLES+1 cycles.
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= StIdle;
         idx_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         rwn_q   <= 1'b1;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rwn_q   <= rwn_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      cfg_valid_o = '0;
      if (state_q == StReq) begin
         for (int unsigned i = 0; i < N_PERIPHS; i++) begin
            cfg_valid_o[i] = (idx_q == 5'(i));
         end
      end
   end

   assign cfg_addr_o = addr_q;
   assign cfg_data_o = data_q;
   assign cfg_rwn_o  = rwn_q;

   assign pready_o  = (state_q == StDone);
   assign prdata_o  = pready_o ? rdata_q : 32'h0;
   assign pslverr_o = pready_o & err_q;

endmodule

// File: tb/tb_udma_apb_cfg_bridge.sv
// Scoreboard bench for udma_apb_cfg_bridge: expected APB completions and cfg requests are
// queued by the stimulus and checked by independent monitors on the falling edge.
module tb_udma_apb_cfg_bridge;

   localparam int N = 8;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } apb_exp_t;

   typedef struct {
      logic [7:0]  vec;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        rwn;
      int          len;
   } cfg_exp_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          psel = 1'b0;
   logic          penable = 1'b0;
   logic          pwrite = 1'b0;
   logic [11:0]   paddr = '0;
   logic [31:0]   pwdata = '0;
   logic [31:0]   prdata;
   logic          pready;
   logic          pslverr;
   logic [N-1:0]  cfg_valid;
   logic [4:0]    cfg_addr;
   logic [31:0]   cfg_data;
   logic          cfg_rwn;
   logic [N*32-1:0] cfg_rdata;
   logic [N-1:0]  cfg_ready;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   apb_exp_t apb_q[$];
   cfg_exp_t cfg_q[$];

   int unsigned dly [N];
   int unsigned wcnt = 0;
   logic [31:0] mem [N][32];
   logic        loaded = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   udma_apb_cfg_bridge dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .psel_i      (psel),
      .penable_i   (penable),
      .pwrite_i    (pwrite),
      .paddr_i     (paddr),
      .pwdata_i    (pwdata),
      .prdata_o    (prdata),
      .pready_o    (pready),
      .pslverr_o   (pslverr),
      .cfg_valid_o (cfg_valid),
      .cfg_addr_o  (cfg_addr),
      .cfg_data_o  (cfg_data),
      .cfg_rwn_o   (cfg_rwn),
      .cfg_data_i  (cfg_rdata),
      .cfg_ready_i (cfg_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Responder model: ready rises dly[p] cycles after valid; register file preloaded.
   always_comb begin
      cfg_ready = '0;
      cfg_rdata = '0;
      for (int p = 0; p < N; p++) begin
         cfg_ready[p]           = cfg_valid[p] && (wcnt >= dly[p]);
         cfg_rdata[p*32 +: 32]  = mem[p][cfg_addr];
      end
   end

   always @(posedge clk) begin
      if ((cfg_valid != '0) && ((cfg_valid & cfg_ready) == '0)) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (!loaded) begin
         for (int p = 0; p < N; p++)
            for (int a = 0; a < 32; a++)
               mem[p][a] <= {8'hC0, 8'(p), 8'h00, 8'(a)};
         mem[2][16] <= 32'h1234_5678;
         loaded <= 1'b1;
      end else begin
         for (int p = 0; p < N; p++)
            if (cfg_valid[p] && cfg_ready[p] && !cfg_rwn) mem[p][cfg_addr] <= cfg_data;
      end
   end

   // APB completion monitor.
   always @(negedge clk) begin
      apb_exp_t e;
      if (rstn && pready) begin
         if (apb_q.size() == 0) begin
            chk("apb_unexpected_pready", 32'(pready), 32'h0);
         end else begin
            e = apb_q.pop_front();
            chk("prdata", prdata, e.rdata);
            chk("pslverr", 32'(pslverr), 32'(e.err));
            chk("apb_latency", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // cfg request monitor: contents every valid cycle, length when valid falls.
   cfg_exp_t ce;
   bit       active = 1'b0;
   int       nval = 0;
   always @(negedge clk) begin
      if (cfg_valid != '0) begin
         if (!active) begin
            if (cfg_q.size() == 0) chk("cfg_unexpected_valid", 32'(cfg_valid), 32'h0);
            else begin
               ce     = cfg_q.pop_front();
               active = 1'b1;
               nval   = 0;
            end
         end
         if (active) begin
            nval++;
            chk("cfg_valid", 32'(cfg_valid), 32'(ce.vec));
            chk("cfg_addr", 32'(cfg_addr), 32'(ce.addr));
            chk("cfg_data", cfg_data, ce.data);
            chk("cfg_rwn", 32'(cfg_rwn), 32'(ce.rwn));
         end
      end else if (active) begin
         chk("cfg_valid_len", 32'(nval), 32'(ce.len));
         active = 1'b0;
      end
   end

   // Starts at posedge+1 and returns at posedge+1 of the cycle after DONE.
   task automatic apb(input bit wr, input logic [11:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input bit exp_err, input int lat);
      apb_exp_t e;
      bit seen;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wdata;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.cyc   = cyc + lat;
      apb_q.push_back(e);
      @(posedge clk); #1;
      penable = 1'b1;
      // Access-phase changes must be ignored by the bridge.
      pwrite  = ~wr;
      paddr   = ~addr;
      pwdata  = ~wdata;
      seen    = 1'b0;
      for (int n = 0; n < 400 && !seen; n++) begin
         @(negedge clk);
         seen = pready;
      end
      if (!seen) chk("pready_timeout", 32'h0, 32'h1);
      @(posedge clk); #1;
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   task automatic push_cfg(input logic [7:0] vec, input logic [4:0] addr,
                           input logic [31:0] data, input logic rwn, input int len);
      cfg_exp_t c;
      c.vec = vec; c.addr = addr; c.data = data; c.rwn = rwn; c.len = len;
      cfg_q.push_back(c);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_cfg_valid", 32'(cfg_valid), 32'h0);
      chk("rst_cfg_addr", 32'(cfg_addr), 32'h0);
      chk("rst_cfg_data", cfg_data, 32'h0);
      chk("rst_cfg_rwn", 32'(cfg_rwn), 32'h1);
      chk("rst_prdata", prdata, 32'h0);
      chk("rst_pready", 32'(pready), 32'h0);
      chk("rst_pslverr", 32'(pslverr), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int p = 0; p < N; p++) dly[p] = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs();
      rstn = 1'b1;
      @(posedge clk); #1;

      // Write, ready tied high.
      push_cfg(8'h01, 5'h01, 32'h0403_0201, 1'b0, 1);
      apb(1'b1, 12'h004, 32'h0403_0201, 32'h0, 1'b0, 2);

      // Read periph 2 reg 0x10, ready after 3 cycles.
      dly[2] = 3;
      push_cfg(8'h04, 5'h10, 32'h0, 1'b1, 4);
      apb(1'b0, 12'h140, 32'h0, 32'h1234_5678, 1'b0, 5);

      // Out-of-range peripheral index 8.
      apb(1'b0, 12'h400, 32'h0, 32'h0, 1'b1, 1);

      // Low address bits ignored: periph 5 reg 31.
      push_cfg(8'h20, 5'h1F, 32'h0, 1'b1, 1);
      apb(1'b0, 12'h2FF, 32'h0, 32'hC005_001F, 1'b0, 2);

      // Timeout on periph 3, then a normal read of periph 0.
      dly[3] = 1000;
      push_cfg(8'h08, 5'h02, 32'h0, 1'b1, 256);
      apb(1'b0, 12'h188, 32'h0, 32'h0, 1'b1, 257);
      push_cfg(8'h01, 5'h05, 32'h0, 1'b1, 1);
      apb(1'b0, 12'h014, 32'h0, 32'hC000_0005, 1'b0, 2);

      // Reset while a stalled request is pending.
      push_cfg(8'h08, 5'h01, 32'hDEAD_0001, 1'b1, 3);
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = 12'h184;
      pwdata  = 32'hDEAD_0001;
      @(posedge clk); #1;
      penable = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b0;
      #1;
      chk_reset_outputs();
      psel    = 1'b0;
      penable = 1'b0;
      dly[3]  = 0;
      @(posedge clk); #1;
      rstn = 1'b1;
      push_cfg(8'h01, 5'h00, 32'h0, 1'b1, 1);
      apb(1'b0, 12'h000, 32'h0, 32'hC000_0000, 1'b0, 2);

      // Back-to-back write then read-back through a stalling responder.
      dly[1] = 2;
      push_cfg(8'h02, 5'h02, 32'h0000_00A5, 1'b0, 3);
      apb(1'b1, 12'h088, 32'h0000_00A5, 32'h0, 1'b0, 4);
      push_cfg(8'h02, 5'h02, 32'h0, 1'b1, 3);
      apb(1'b0, 12'h088, 32'h0, 32'h0000_00A5, 1'b0, 4);

      repeat (4) @(posedge clk);
      #1;
      chk("apb_queue_drained", 32'(apb_q.size()), 32'h0);
      chk("cfg_queue_drained", 32'(cfg_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
